// File: rtl/add7_pkg.sv
// Shared widths and FSM state type for the 7-bit adder collector stage.
package add7_pkg;
  localparam int unsigned ADD7_W = 7;
  localparam int unsigned BEAT_W = 8;

  typedef enum logic {S_ACC, S_STALL} state_e;
endpackage

// File: rtl/add_sat_unit.sv
// Combinational accumulate of one beat into the running total.
// Flags carry-out of the ACC_W-bit sum and optionally clamps the result to all-ones.
module add_sat_unit
  import add7_pkg::*;
#(
  parameter int unsigned ACC_W    = 12,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);
  logic [ACC_W:0] w_nxt;

  assign w_nxt = {1'b0, i_acc} + {{(ACC_W + 1 - BEAT_W){1'b0}}, i_beat};
  assign o_ovf = w_nxt[ACC_W];
  assign o_sum = (o_ovf && SATURATE) ? {ACC_W{1'b1}} : w_nxt[ACC_W-1:0];
endmodule

// File: rtl/add7_sum_collector.sv
// Collects {cout,sum} beats into per-frame totals and hands each finished frame to a
// single-slot valid/ready output register; stalls input only when a finished frame is stuck.
module add7_sum_collector
  import add7_pkg::*;
#(
  parameter int unsigned ACC_W    = 12,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADD7_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);
  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic [BEAT_W-1:0]  w_beat;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic               w_ovf_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_accept;
  logic               w_slot_free;

  assign w_beat      = {in_cout, in_sum};
  assign w_ovf_nxt   = r_ovf | w_add_ovf;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign in_ready    = (r_state == S_ACC);
  assign w_accept    = in_valid & in_ready;
  assign w_slot_free = ~r_out_valid | out_ready;

  add_sat_unit #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .i_acc  (r_acc),
    .i_beat (w_beat),
    .o_sum  (w_sum),
    .o_ovf  (w_add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      // Drain by default; a load below in the same cycle keeps the slot full with no bubble.
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      if (clr) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_state <= S_ACC;
      end else begin
        case (r_state)
          S_ACC: begin
            if (w_accept) begin
              if (!in_last) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
                r_ovf <= w_ovf_nxt;
              end else if (w_slot_free) begin
                r_out_sum   <= w_sum;
                r_out_count <= w_cnt_inc;
                r_out_ovf   <= w_ovf_nxt;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
              end else begin
                r_acc   <= w_sum;
                r_cnt   <= w_cnt_inc;
                r_ovf   <= w_ovf_nxt;
                r_state <= S_STALL;
              end
            end
          end
          S_STALL: begin
            if (out_ready) begin
              r_out_sum   <= r_acc;
              r_out_count <= r_cnt;
              r_out_ovf   <= r_ovf;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_ovf       <= 1'b0;
              r_state     <= S_ACC;
            end
          end
          default: r_state <= S_ACC;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_add7_sum_collector.sv
// Scoreboard bench: three collector configurations share one stimulus stream; a frame-level
// model queues expected results and a negedge monitor checks each output handshake.
module tb_add7_sum_collector;
  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_cout, in_last, out_ready;
  logic [6:0] in_sum;

  logic        rdy[3];
  logic        o_valid[3];
  logic [11:0] o_sum[3];
  logic [7:0]  o_cnt[3];
  logic [3:0]  o_cnt_c;
  logic        o_ovf[3];

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_ready = 1'b0;

  // Configs: 0 = saturate/8-bit count, 1 = wrap/8-bit count, 2 = saturate/4-bit count
  int sat_cfg[3]  = '{1, 0, 1};
  int cmax_cfg[3] = '{255, 255, 15};
  int m_acc[3];
  int m_cnt[3];
  int m_ovf[3];

  typedef struct {
    int s0, s1, s2;
    int c0, c1, c2;
    int v0, v1, v2;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  add7_sum_collector #(.ACC_W(12), .CNT_W(8), .SATURATE(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_sum(o_sum[0]), .out_count(o_cnt[0]), .out_ovf(o_ovf[0])
  );
  add7_sum_collector #(.ACC_W(12), .CNT_W(8), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_sum(o_sum[1]), .out_count(o_cnt[1]), .out_ovf(o_ovf[1])
  );
  add7_sum_collector #(.ACC_W(12), .CNT_W(4), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_sum(in_sum), .in_cout(in_cout), .in_last(in_last), .out_valid(o_valid[2]),
    .out_ready(out_ready), .out_sum(o_sum[2]), .out_count(o_cnt_c), .out_ovf(o_ovf[2])
  );
  assign o_cnt[2] = {4'b0000, o_cnt_c};

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 0;
    end
  endfunction

  function automatic void model_beat(input int v, input bit last);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      int nxt;
      nxt = m_acc[k] + v;
      if (nxt > 4095) begin
        m_ovf[k] = 1;
        m_acc[k] = (sat_cfg[k] != 0) ? 4095 : nxt - 4096;
      end else begin
        m_acc[k] = nxt;
      end
      if (m_cnt[k] < cmax_cfg[k]) m_cnt[k]++;
    end
    if (last) begin
      e.s0 = m_acc[0]; e.s1 = m_acc[1]; e.s2 = m_acc[2];
      e.c0 = m_cnt[0]; e.c1 = m_cnt[1]; e.c2 = m_cnt[2];
      e.v0 = m_ovf[0]; e.v1 = m_ovf[1]; e.v2 = m_ovf[2];
      exp_q.push_back(e);
      model_clear();
    end
  endfunction

  // Present one beat and hold it until accepted; model updates at the accepting edge.
  task automatic send(input int v, input bit last);
    logic [7:0] b;
    bit done;
    int waited;
    b = v[7:0];
    done = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_cout = b[7];
    in_sum = b[6:0];
    in_last = last;
    while (!done) begin
      @(negedge clk);
      if (rdy[0] && !clr) begin
        model_beat(v, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 200) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Monitor: compare every output transfer against the queue; hold-stability under back-pressure.
  initial begin
    logic        prev_valid;
    logic        prev_ready;
    logic [11:0] prev_sum;
    exp_t        e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_sum = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (o_valid[1] != o_valid[0] || o_valid[2] != o_valid[0])
          chk("valid_agree", {o_valid[0], o_valid[1], o_valid[2]}, o_valid[0] ? 7 : 0);
        if (prev_valid && !prev_ready) chk("hold_stable", int'(o_sum[0]), int'(prev_sum));
        if (o_valid[0] && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(o_sum[0]), -1);
          end else begin
            e = exp_q.pop_front();
            chk("sum0", int'(o_sum[0]), e.s0);
            chk("sum1", int'(o_sum[1]), e.s1);
            chk("sum2", int'(o_sum[2]), e.s2);
            chk("cnt0", int'(o_cnt[0]), e.c0);
            chk("cnt1", int'(o_cnt[1]), e.c1);
            chk("cnt2", int'(o_cnt[2]), e.c2);
            chk("ovf0", int'(o_ovf[0]), e.v0);
            chk("ovf1", int'(o_ovf[1]), e.v1);
            chk("ovf2", int'(o_ovf[2]), e.v2);
          end
        end
        prev_valid = o_valid[0];
        prev_ready = out_ready;
        prev_sum = o_sum[0];
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_cout = 1'b0;
    in_sum = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    model_clear();
    cycles(2);
    chk("rst_valid", int'(o_valid[0]), 0);
    chk("rst_sum", int'(o_sum[0]), 0);
    rst_n = 1'b1;
    cycles(1);
    chk("rst_in_ready", int'(rdy[0]), 1);

    // Basic frame: 127 + 128 + 5
    send(127, 1'b0);
    send(128, 1'b0);
    send(5, 1'b1);
    chk("t1_valid_latency", int'(o_valid[0]), 1);
    chk("t1_sum", int'(o_sum[0]), 260);
    chk("t1_count", int'(o_cnt[0]), 3);
    chk("t1_ovf", int'(o_ovf[0]), 0);
    cycles(2);

    // Overflow: 20 x 255
    for (int i = 0; i < 20; i++) send(255, i == 19);
    chk("t2_sat_sum", int'(o_sum[0]), 4095);
    chk("t2_sat_ovf", int'(o_ovf[0]), 1);
    chk("t2_wrap_sum", int'(o_sum[1]), 1004);
    chk("t2_wrap_ovf", int'(o_ovf[1]), 1);
    cycles(2);

    // Back-pressure: A held, B finished behind it
    out_ready = 1'b0;
    send(9, 1'b1);
    send(3, 1'b1);
    chk("t3_in_ready_stall", int'(rdy[0]), 0);
    chk("t3_sum_held", int'(o_sum[0]), 9);
    cycles(3);
    chk("t3_sum_still", int'(o_sum[0]), 9);
    out_ready = 1'b1;
    cycles(1);
    chk("t3_sum_b", int'(o_sum[0]), 3);
    chk("t3_valid_kept", int'(o_valid[0]), 1);
    chk("t3_in_ready_back", int'(rdy[0]), 1);
    cycles(2);

    // Clear while stalled drops B
    out_ready = 1'b0;
    send(9, 1'b1);
    send(3, 1'b1);
    chk("t4_stalled", int'(rdy[0]), 0);
    void'(exp_q.pop_back());
    pulse_clr();
    chk("t4_in_ready", int'(rdy[0]), 1);
    chk("t4_sum_held", int'(o_sum[0]), 9);
    chk("t4_valid_held", int'(o_valid[0]), 1);
    out_ready = 1'b1;
    cycles(3);
    chk("t4_b_dropped", int'(o_valid[0]), 0);

    // Count saturation on the 4-bit counter
    for (int i = 0; i < 20; i++) send(1, i == 19);
    chk("t5_cnt4", int'(o_cnt[2]), 15);
    chk("t5_sum4", int'(o_sum[2]), 20);
    chk("t5_cnt8", int'(o_cnt[0]), 20);
    cycles(2);

    // Reset mid-frame with a held result
    out_ready = 1'b0;
    send(10, 1'b1);
    send(4, 1'b0);
    send(6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(o_valid[0]), 0);
    chk("t6_sum", int'(o_sum[0]), 0);
    chk("t6_count", int'(o_cnt[0]), 0);
    chk("t6_ovf", int'(o_ovf[0]), 0);
    exp_q.delete();
    model_clear();
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    chk("t6_in_ready", int'(rdy[0]), 1);
    out_ready = 1'b1;
    send(7, 1'b1);
    chk("t6_sum7", int'(o_sum[0]), 7);
    chk("t6_count1", int'(o_cnt[0]), 1);
    cycles(2);

    // Random traffic with random back-pressure and occasional clears between beats
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(int'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) cycles(1);
      if ($urandom_range(0, 29) == 0 && rdy[0]) begin
        model_clear();
        pulse_clr();
      end
    end
    send(int'($urandom_range(0, 255)), 1'b1);
    rand_ready = 1'b0;
    cycles(1);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
